switch_debouncer: RTL

SWITCH_DEBOUNCER -- requirements
Module: switch_debouncer

---
 rtl/switch_debouncer.sv | 103 ++++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// switch_debouncer: 16-bit slide-switch debouncer with two-flop input
// synchronizers and one independent stability counter per bit.
// A new synchronized level is accepted once it differs from O on
// DEBOUNCE_CYCLES consecutive edges. Any return to the accepted level
// clears that bit's count.
// Optional feature macro: SWITCH_DEBOUNCER_EDGE_EN enables the registered
// rise/fall/any_change pulse outputs. When it is undefined, those outputs
// are tied to zero.
module switch_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned CNT_W           = 24
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] I,
  output logic [15:0] O,
  output logic [15:0] rise,
  output logic [15:0] fall,
  output logic        any_change
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [15:0]      s1_q;
  logic [15:0]      s2_q;
  logic [15:0]      o_q;
  logic [15:0]      o_d;
  logic [CNT_W-1:0] cnt_q [16];
  logic [CNT_W-1:0] cnt_d [16];

  // Two-flop synchronizer ahead of all other logic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= I;
      s2_q <= s1_q;
    end
  end

  // Per-bit stability count and acceptance decision.
  // The comparison uses >= so that a counter can never stick above the limit.
  always_comb begin
    o_d = o_q;
    for (int unsigned i = 0; i < 16; i++) begin
      cnt_d[i] = '0;
      if (s2_q[i] != o_q[i]) begin
        if (cnt_q[i] >= CNT_LAST) begin
          o_d[i] = s2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Counter and debounced-level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_q <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      o_q <= o_d;
      for (int unsigned i = 0; i < 16; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign O = o_q;

`ifdef SWITCH_DEBOUNCER_EDGE_EN
  logic [15:0] rise_q;
  logic [15:0] fall_q;
  logic        any_q;

  // Edge pulses are derived from next vs current O.
  // Each pulse therefore lines up with the first cycle that shows the new level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_q <= '0;
      fall_q <= '0;
      any_q  <= 1'b0;
    end else begin
      rise_q <= o_d & ~o_q;
      fall_q <= ~o_d & o_q;
      any_q  <= |(o_d ^ o_q);
    end
  end

  assign rise       = rise_q;
  assign fall       = fall_q;
  assign any_change = any_q;
`else
  assign rise       = '0;
  assign fall       = '0;
  assign any_change = 1'b0;
`endif

endmodule
